// File: rtl/serial_adder_if.sv
// Operand/result valid-ready bus for the serial adder.
// The slave modport is the adder's side of the bus and the master modport is the producer/consumer side.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: one SLICE-bit ripple stage with a registered carry,
// producing a WIDTH-bit result in WIDTH/SLICE cycles behind valid/ready handshakes.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int unsigned N     = WIDTH / SLICE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("serial_adder: WIDTH must be >= 2");
    end
    if ((SLICE == 0) || ((WIDTH % SLICE) != 0)) begin : g_bad_slice
      $error("serial_adder: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic             load_c;
  logic             step_c;
  logic             last_c;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cout_q;
  logic             ovf_q;

  logic [SLICE:0]   carry_c;
  logic [SLICE-1:0] slice_sum_c;

  // State register; handshake outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_next;
      in_ready_q  <= (state_next == IDLE);
      out_valid_q <= (state_next == DONE);
    end
  end

  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    step_c     = 1'b0;
    last_c     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          load_c     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step_c = 1'b1;
        if (cnt_q == LAST) begin
          last_c     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One SLICE-bit ripple stage fed from the operand LSBs
  always_comb begin
    carry_c     = '0;
    slice_sum_c = '0;
    carry_c[0]  = carry_q;
    for (int i = 0; i < int'(SLICE); i++) begin
      slice_sum_c[i] = a_q[i] ^ b_q[i] ^ carry_c[i];
      carry_c[i+1]   = (a_q[i] & b_q[i]) | (carry_c[i] & (a_q[i] ^ b_q[i]));
    end
  end

  // Subtraction is folded in at load time: invert b and seed the carry with 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (load_c) begin
      a_q     <= bus.a;
      b_q     <= bus.b ^ {WIDTH{bus.sub}};
      carry_q <= bus.sub ? 1'b1 : bus.cin;
      cnt_q   <= '0;
    end else if (step_c) begin
      a_q     <= a_q >> SLICE;
      b_q     <= b_q >> SLICE;
      sum_q   <= (sum_q >> SLICE) | (WIDTH'(slice_sum_c) << (WIDTH - SLICE));
      carry_q <= carry_c[SLICE];
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last_c) begin
        cout_q <= carry_c[SLICE];
        ovf_q  <= carry_c[SLICE] ^ carry_c[SLICE-1];
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: a bit-serial instance (SLICE=1) and a nibble instance (SLICE=4),
// checked against a plain-arithmetic reference model.
module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  serial_adder_if #(.WIDTH(WIDTH)) b1 ();
  serial_adder_if #(.WIDTH(WIDTH)) b4 ();

  serial_adder #(.WIDTH(WIDTH), .SLICE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  serial_adder #(.WIDTH(WIDTH), .SLICE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: full-width integer sum and signed range test
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub, output logic [7:0] es, output logic ec,
                       output logic eo);
    logic [7:0]  bb;
    logic        c0;
    int unsigned tot;
    int          sr;
    bb  = sub ? ~b : b;
    c0  = sub ? 1'b1 : cin;
    tot = int'(a) + int'(bb) + int'(c0);
    es  = tot[7:0];
    ec  = tot[8];
    sr  = int'($signed(a)) + int'($signed(bb)) + int'(c0);
    eo  = (sr > 127) || (sr < -128);
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 1) ? b1.in_ready : b4.in_ready;
  endfunction

  function automatic logic ovld(input int sel);
    return (sel == 1) ? b1.out_valid : b4.out_valid;
  endfunction

  task automatic drive_in(input int sel, input logic v, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub);
    if (sel == 1) begin
      b1.in_valid = v; b1.a = a; b1.b = b; b1.cin = cin; b1.sub = sub;
    end else begin
      b4.in_valid = v; b4.a = a; b4.b = b; b4.cin = cin; b4.sub = sub;
    end
  endtask

  task automatic set_ordy(input int sel, input logic v);
    if (sel == 1) b1.out_ready = v;
    else          b4.out_ready = v;
  endtask

  task automatic get_out(input int sel, output logic [7:0] s, output logic c, output logic o);
    if (sel == 1) begin s = b1.sum; c = b1.cout; o = b1.ovf; end
    else          begin s = b4.sum; c = b4.cout; o = b4.ovf; end
  endtask

  // Wait (bounded) until out_valid, returning the number of edges waited
  task automatic wait_valid(input int sel, output int lat);
    lat = 0;
    while (!ovld(sel) && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic xact(input int sel, input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic sub, output logic [7:0] s, output logic c, output logic o);
    logic [7:0] es;
    logic       ec, eo;
    int         n, lat, wt;
    string      tag;
    tag = (sel == 1) ? "s1" : "s4";
    n   = (sel == 1) ? 8 : 2;
    model(a, b, cin, sub, es, ec, eo);
    wt = 0;
    while (!rdy(sel) && wt < 50) begin
      tick();
      wt++;
    end
    check({tag, "_in_ready"}, 32'(rdy(sel)), 32'(1));
    drive_in(sel, 1'b1, a, b, cin, sub);
    tick();
    // Scramble operands after accept: the DUT must have sampled them already
    drive_in(sel, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    wait_valid(sel, lat);
    check({tag, "_latency"}, 32'(lat), 32'(n));
    repeat ($urandom_range(0, 2)) tick();
    get_out(sel, s, c, o);
    check({tag, "_sum"}, 32'(s), 32'(es));
    check({tag, "_cout"}, 32'(c), 32'(ec));
    check({tag, "_ovf"}, 32'(o), 32'(eo));
    set_ordy(sel, 1'b1);
    tick();
    set_ordy(sel, 1'b0);
    check({tag, "_retire"}, 32'(ovld(sel)), 32'(0));
  endtask

  initial begin
    logic [7:0] s;
    logic       c, o;
    logic [7:0] corners [5];
    int         lat;
    checks   = 0;
    failures = 0;
    corners  = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    drive_in(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    drive_in(4, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    set_ordy(1, 1'b0);
    set_ordy(4, 1'b0);
    rst_n = 1'b0;
    #23;
    check("rst_out_valid", 32'(b1.out_valid), 32'(0));
    check("rst_sum", 32'(b1.sum), 32'(0));
    check("rst_cout", 32'(b1.cout), 32'(0));
    check("rst_ovf", 32'(b1.ovf), 32'(0));
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(b1.in_ready), 32'(1));
    check("rst_in_ready4", 32'(b4.in_ready), 32'(1));

    // Directed cases with hand-computed results
    xact(1, 8'h5A, 8'h3C, 1'b0, 1'b0, s, c, o);
    check("t1_sum", 32'(s), 32'h96); check("t1_cout", 32'(c), 32'(0)); check("t1_ovf", 32'(o), 32'(1));
    xact(1, 8'hFF, 8'h01, 1'b0, 1'b0, s, c, o);
    check("t2_sum", 32'(s), 32'h00); check("t2_cout", 32'(c), 32'(1)); check("t2_ovf", 32'(o), 32'(0));
    xact(1, 8'h10, 8'h20, 1'b1, 1'b1, s, c, o);
    check("t3a_sum", 32'(s), 32'hF0); check("t3a_cout", 32'(c), 32'(0)); check("t3a_ovf", 32'(o), 32'(0));
    xact(1, 8'h80, 8'h01, 1'b0, 1'b1, s, c, o);
    check("t3b_sum", 32'(s), 32'h7F); check("t3b_cout", 32'(c), 32'(1)); check("t3b_ovf", 32'(o), 32'(1));

    // Backpressure: result held while the next pair waits on in_valid
    drive_in(1, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
    tick();
    drive_in(1, 1'b1, 8'h0F, 8'h01, 1'b1, 1'b0);
    wait_valid(1, lat);
    check("bp_latency", 32'(lat), 32'(8));
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(b1.out_valid), 32'(1));
      check("bp_sum", 32'(b1.sum), 32'h46);
      check("bp_in_ready", 32'(b1.in_ready), 32'(0));
      tick();
    end
    set_ordy(1, 1'b1);
    tick();
    set_ordy(1, 1'b0);
    check("bp_retired", 32'(b1.out_valid), 32'(0));
    check("bp_idle_ready", 32'(b1.in_ready), 32'(1));
    tick();
    check("bp_accepted", 32'(b1.in_ready), 32'(0));
    drive_in(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    wait_valid(1, lat);
    check("bp2_latency", 32'(lat), 32'(8));
    check("bp2_sum", 32'(b1.sum), 32'h11);
    set_ordy(1, 1'b1);
    tick();
    set_ordy(1, 1'b0);

    // Reset in the middle of RUN clears outputs without a clock edge
    drive_in(1, 1'b1, 8'h33, 8'h44, 1'b0, 1'b0);
    tick();
    drive_in(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(b1.out_valid), 32'(0));
    check("mid_rst_sum", 32'(b1.sum), 32'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    xact(1, 8'h01, 8'h02, 1'b0, 1'b0, s, c, o);
    check("post_rst_sum", 32'(s), 32'h03);

    for (int i = 0; i < 200; i++)
      xact(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), s, c, o);

    // Nibble-slice instance: operand corners then random pairs
    foreach (corners[i]) foreach (corners[j])
      for (int m = 0; m < 4; m++)
        xact(4, corners[i], corners[j], m[0], m[1], s, c, o);
    for (int i = 0; i < 1500; i++)
      xact(4, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), s, c, o);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
